// File: rtl/hamming_link_ctrl.sv
// Frame sequencer for the serial extended-Hamming (16,11) link.
// Optional WAIT timeout is enabled with `define LINK_CTRL_TIMEOUT_EN.
module hamming_link_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [10:0]      in_data,
    input  logic             in_err_en,
    input  logic [3:0]       in_addr1,
    input  logic [3:0]       in_addr2,
    output logic             enc_bit,
    output logic             enc_strobe,
    output logic             nz_enable,
    output logic [3:0]       nz_addr1,
    output logic [3:0]       nz_addr2,
    input  logic             dec_done,
    input  logic             dec_parity,
    input  logic [3:0]       dec_check,
    output logic             res_valid,
    output logic [1:0]       res_status,
    output logic [3:0]       res_syndrome,
    output logic             busy,
    output logic [CNT_W-1:0] cnt_single,
    output logic [CNT_W-1:0] cnt_double
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEND   = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_REPORT = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       r_state;
    logic [10:0]      r_frame;
    logic [3:0]       r_idx;
    logic [1:0]       r_status;
    logic [3:0]       r_syn;
    logic             r_nz_en;
    logic [3:0]       r_nz_a1;
    logic [3:0]       r_nz_a2;
    logic [CNT_W-1:0] r_cnt_s;
    logic [CNT_W-1:0] r_cnt_d;

    logic             w_bit;
    logic [1:0]       w_class;
    logic             w_expire;
    logic             w_last;

    assign w_last = (r_state == S_SEND) && (r_idx == 4'd15);

    // Check/parity positions 0,1,2,4,8 go out as zero.
    always_comb begin
        w_bit = 1'b0;
        case (r_idx)
            4'd3:    w_bit = r_frame[0];
            4'd5:    w_bit = r_frame[1];
            4'd6:    w_bit = r_frame[2];
            4'd7:    w_bit = r_frame[3];
            4'd9:    w_bit = r_frame[4];
            4'd10:   w_bit = r_frame[5];
            4'd11:   w_bit = r_frame[6];
            4'd12:   w_bit = r_frame[7];
            4'd13:   w_bit = r_frame[8];
            4'd14:   w_bit = r_frame[9];
            4'd15:   w_bit = r_frame[10];
            default: w_bit = 1'b0;
        endcase
    end

    always_comb begin
        w_class = 2'b00;
        if (dec_parity)
            w_class = 2'b01;
        else if (dec_check != 4'd0)
            w_class = 2'b10;
    end

`ifdef LINK_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_tmo;

    always_ff @(posedge clk) begin
        if (rst)
            r_tmo <= '0;
        else if (w_last)
            r_tmo <= TW'(TIMEOUT);
        else if (r_state == S_WAIT && r_tmo != '0)
            r_tmo <= r_tmo - TW'(1);
    end

    assign w_expire = (r_state == S_WAIT) && (r_tmo == '0);
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_frame  <= '0;
            r_idx    <= '0;
            r_status <= '0;
            r_syn    <= '0;
            r_nz_en  <= 1'b0;
            r_nz_a1  <= '0;
            r_nz_a2  <= '0;
            r_cnt_s  <= '0;
            r_cnt_d  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_frame <= in_data;
                        r_nz_en <= in_err_en;
                        r_nz_a1 <= in_addr1;
                        r_nz_a2 <= in_addr2;
                        r_idx   <= '0;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    r_idx <= r_idx + 4'd1;
                    if (r_idx == 4'd15)
                        r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A completion in the expiry cycle takes priority.
                    if (dec_done) begin
                        r_status <= w_class;
                        r_syn    <= dec_check;
                        r_state  <= S_REPORT;
                    end else if (w_expire) begin
                        r_status <= 2'b11;
                        r_syn    <= 4'd0;
                        r_state  <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    if (r_status == 2'b01 && r_cnt_s != CNT_MAX)
                        r_cnt_s <= r_cnt_s + CNT_W'(1);
                    if (r_status == 2'b10 && r_cnt_d != CNT_MAX)
                        r_cnt_d <= r_cnt_d + CNT_W'(1);
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready     = (r_state == S_IDLE) && !rst;
    assign busy         = (r_state != S_IDLE);
    assign enc_strobe   = (r_state == S_SEND);
    assign enc_bit      = (r_state == S_SEND) && w_bit;
    assign nz_enable    = r_nz_en;
    assign nz_addr1     = r_nz_a1;
    assign nz_addr2     = r_nz_a2;
    assign res_valid    = (r_state == S_REPORT);
    assign res_status   = r_status;
    assign res_syndrome = r_syn;
    assign cnt_single   = r_cnt_s;
    assign cnt_double   = r_cnt_d;

endmodule

// File: tb/tb_hamming_link_ctrl.sv
// Directed bench for hamming_link_ctrl with a result scoreboard.
// Timeout checks run only when LINK_CTRL_TIMEOUT_EN is defined.
module tb_hamming_link_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [10:0] in_data = '0;
    logic        in_err_en = 1'b0;
    logic [3:0]  in_addr1 = '0;
    logic [3:0]  in_addr2 = '0;
    logic        enc_bit;
    logic        enc_strobe;
    logic        nz_enable;
    logic [3:0]  nz_addr1;
    logic [3:0]  nz_addr2;
    logic        dec_done = 1'b0;
    logic        dec_parity = 1'b0;
    logic [3:0]  dec_check = '0;
    logic        res_valid;
    logic [1:0]  res_status;
    logic [3:0]  res_syndrome;
    logic        busy;
    logic [7:0]  cnt_single;
    logic [7:0]  cnt_double;

    int n_cmp = 0;
    int n_bad = 0;
    logic [5:0] sb[$];

    hamming_link_ctrl #(.TIMEOUT(64), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_err_en(in_err_en), .in_addr1(in_addr1), .in_addr2(in_addr2),
        .enc_bit(enc_bit), .enc_strobe(enc_strobe),
        .nz_enable(nz_enable), .nz_addr1(nz_addr1), .nz_addr2(nz_addr2),
        .dec_done(dec_done), .dec_parity(dec_parity), .dec_check(dec_check),
        .res_valid(res_valid), .res_status(res_status),
        .res_syndrome(res_syndrome), .busy(busy),
        .cnt_single(cnt_single), .cnt_double(cnt_double)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mkframe(input logic [10:0] d);
        logic [15:0] f;
        int j;
        f = '0;
        j = 0;
        for (int p = 0; p < 16; p++) begin
            if (p != 0 && p != 1 && p != 2 && p != 4 && p != 8) begin
                f[p] = d[j];
                j++;
            end
        end
        return f;
    endfunction

    // Scoreboard consumer: every result pulse must match a queued entry.
    always @(negedge clk) begin
        if (res_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_res_valid", 32'd1, 32'd0);
            end else begin
                logic [5:0] e;
                e = sb.pop_front();
                chk("res_status", {30'd0, res_status}, {30'd0, e[5:4]});
                chk("res_syndrome", {28'd0, res_syndrome}, {28'd0, e[3:0]});
            end
        end
    end

    task automatic start_frame(input logic [10:0] d, input logic en,
                               input logic [3:0] a1, input logic [3:0] a2);
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        in_valid  = 1'b1;
        in_data   = d;
        in_err_en = en;
        in_addr1  = a1;
        in_addr2  = a2;
    endtask

    task automatic stream(input logic [10:0] d, input logic en,
                          input logic [3:0] a1, input logic [3:0] a2,
                          input bit hold, input bit inject);
        logic [15:0] f;
        f = mkframe(d);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 0 && !hold) in_valid = 1'b0;
            if (inject && k == 4) begin
                dec_done   = 1'b1;
                dec_parity = 1'b1;
                dec_check  = 4'hF;
            end
            if (inject && k == 5) dec_done = 1'b0;
            chk("enc_strobe", enc_strobe, 1);
            chk("enc_bit", enc_bit, f[k]);
            chk("nz_enable", nz_enable, en);
            chk("nz_addr1", nz_addr1, a1);
            chk("nz_addr2", nz_addr2, a2);
        end
        @(negedge clk);
        chk("strobe_wait", enc_strobe, 0);
        chk("busy_wait", busy, 1);
    endtask

    task automatic finish(input logic p, input logic [3:0] c,
                          input logic [1:0] st, input logic [3:0] sy);
        sb.push_back({st, sy});
        dec_done   = 1'b1;
        dec_parity = p;
        dec_check  = c;
        @(negedge clk);
        dec_done = 1'b0;
        chk("res_valid_pulse", res_valid, 1);
        @(negedge clk);
        chk("res_valid_drop", res_valid, 0);
        chk("ready_after", in_ready, 1);
        chk("status_hold", res_status, st);
        chk("syn_hold", res_syndrome, sy);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strobe", enc_strobe, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_nz_enable", nz_enable, 0);
        chk("rst_cnt_single", cnt_single, 0);
        chk("rst_cnt_double", cnt_double, 0);
        chk("rst_status", res_status, 0);
        rst = 1'b0;

        start_frame(11'h001, 1'b0, 4'h0, 4'h0);
        stream(11'h001, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        finish(1'b0, 4'h0, 2'b00, 4'h0);
        chk("clean_cnt_single", cnt_single, 0);
        chk("clean_cnt_double", cnt_double, 0);

        start_frame(11'h400, 1'b1, 4'hC, 4'hC);
        stream(11'h400, 1'b1, 4'hC, 4'hC, 1'b0, 1'b0);
        finish(1'b1, 4'hC, 2'b01, 4'hC);
        chk("single_cnt_single", cnt_single, 1);
        chk("single_cnt_double", cnt_double, 0);

        start_frame(11'h2A5, 1'b1, 4'h3, 4'h5);
        stream(11'h2A5, 1'b1, 4'h3, 4'h5, 1'b0, 1'b0);
        finish(1'b0, 4'h6, 2'b10, 4'h6);
        chk("double_cnt_double", cnt_double, 1);
        chk("double_cnt_single", cnt_single, 1);

        // Back-to-back frames with in_valid held high.
        start_frame(11'h7FF, 1'b0, 4'h1, 4'h2);
        stream(11'h7FF, 1'b0, 4'h1, 4'h2, 1'b1, 1'b1);
        chk("stray_done_ignored", sb.size(), 0);
        in_data   = 11'h155;
        in_err_en = 1'b1;
        in_addr1  = 4'h9;
        in_addr2  = 4'hA;
        sb.push_back({2'b00, 4'h0});
        dec_done   = 1'b1;
        dec_parity = 1'b0;
        dec_check  = 4'h0;
        @(negedge clk);
        dec_done = 1'b0;
        chk("hs_res_valid", res_valid, 1);
        chk("hs_ready_report", in_ready, 0);
        @(negedge clk);
        chk("hs_ready_n2", in_ready, 1);
        chk("hs_busy_n2", busy, 0);
        chk("hs_strobe_n2", enc_strobe, 0);
        stream(11'h155, 1'b1, 4'h9, 4'hA, 1'b0, 1'b0);
        finish(1'b0, 4'h0, 2'b00, 4'h0);

        // Reset during strobe 7.
        start_frame(11'h3C3, 1'b1, 4'h4, 4'h7);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k == 0) in_valid = 1'b0;
        end
        chk("pre_rst_strobe", enc_strobe, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_strobe", enc_strobe, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_nz_en", nz_enable, 0);
        chk("mid_rst_nz_a1", nz_addr1, 0);
        chk("mid_rst_cnt_single", cnt_single, 0);
        chk("mid_rst_cnt_double", cnt_double, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1);
        dec_done = 1'b1;
        repeat (3) @(negedge clk);
        dec_done = 1'b0;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_res_valid", res_valid, 0);

        start_frame(11'h0F0, 1'b0, 4'h0, 4'h0);
        stream(11'h0F0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
`ifdef LINK_CTRL_TIMEOUT_EN
        sb.push_back({2'b11, 4'h0});
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            chk("tmo_no_pulse", res_valid, 0);
        end
        @(negedge clk);
        chk("tmo_pulse", res_valid, 1);
        @(negedge clk);
        chk("tmo_status", res_status, 2'b11);
        chk("tmo_cnt_single", cnt_single, 0);
        chk("tmo_cnt_double", cnt_double, 0);
`else
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (res_valid || !busy) chk("no_tmo_wait", 0, 1);
        end
        chk("no_tmo_busy", busy, 1);
        finish(1'b0, 4'h0, 2'b00, 4'h0);
`endif

        for (int n = 0; n < 300; n++) begin
            start_frame(11'(n), 1'b1, 4'h5, 4'h5);
            stream(11'(n), 1'b1, 4'h5, 4'h5, 1'b0, 1'b0);
            finish(1'b1, 4'h5, 2'b01, 4'h5);
        end
        chk("sat_cnt_single", cnt_single, 255);
        chk("sat_cnt_double", cnt_double, 0);
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
